// File: rtl/masked_andxor_pipe.sv
// Masked q = (a & b) ^ c on NS-share Boolean-masked operands. Stage 1 registers every
// a_i&b_j term with its own mask, and stage 2 XOR-folds each share row.

// One share row i: registers NS terms t[j] = a_i & b_j ^ m[j], then folds them into q_i.
module masked_andxor_row #(
    parameter int NS    = 3,
    parameter int WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld1,
    input  logic                       ld2,
    input  logic [WIDTH-1:0]           a_i,
    input  logic [NS*WIDTH-1:0]        b_sh,
    input  logic [NS-1:0][WIDTH-1:0]   m,
    output logic [WIDTH-1:0]           q_i
);
    // Each term has its own flop. Nothing may merge two cross terms ahead of this barrier.
    (* keep = "true" *) logic [NS-1:0][WIDTH-1:0] t;
    logic [WIDTH-1:0] fold;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t <= '0;
        end else if (ld1) begin
            for (int j = 0; j < NS; j++)
                t[j] <= (a_i & b_sh[j*WIDTH +: WIDTH]) ^ m[j];
        end
    end

    always_comb begin
        fold = '0;
        for (int j = 0; j < NS; j++)
            fold = fold ^ t[j];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      q_i <= '0;
        else if (ld2) q_i <= fold;
    end
endmodule

module masked_andxor_pipe #(
    parameter int NS    = 3,
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NS*WIDTH-1:0]            a_sh,
    input  logic [NS*WIDTH-1:0]            b_sh,
    input  logic [NS*WIDTH-1:0]            c_sh,
    input  logic [NS*(NS-1)/2*WIDTH-1:0]   rnd,
    input  logic                           rnd_valid,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NS*WIDTH-1:0]            q_sh,
    output logic [CNT_W-1:0]               op_cnt
);
    localparam int RW = NS*(NS-1)/2*WIDTH;

    // Lexicographic index of pair (lo, hi), where lo < hi.
    function automatic int pair_idx(input int lo, input int hi);
        return lo*NS - lo*(lo+1)/2 + (hi - lo - 1);
    endfunction

    logic s1_valid, s2_free, acc, ld2;
    logic [NS-1:0][NS-1:0][WIDTH-1:0] m;

    assign s2_free  = !out_valid | out_ready;
    assign in_ready = !s1_valid | s2_free;
    assign acc      = in_valid & rnd_valid & in_ready;
    assign ld2      = s1_valid & s2_free;

    // The inner term is masked by c_i. Terms (i,j) and (j,i) share the pair's fresh slice.
    always_comb begin
        m = '0;
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NS; j++)
                if (i == j) m[i][j] = c_sh[i*WIDTH +: WIDTH];
                else        m[i][j] = rnd[pair_idx(i < j ? i : j, i < j ? j : i)*WIDTH +: WIDTH];
    end

    for (genvar i = 0; i < NS; i++) begin : g_row
        masked_andxor_row #(.NS(NS), .WIDTH(WIDTH)) u_row (
            .clk  (clk),
            .rst  (rst),
            .ld1  (acc),
            .ld2  (ld2),
            .a_i  (a_sh[i*WIDTH +: WIDTH]),
            .b_sh (b_sh),
            .m    (m[i]),
            .q_i  (q_sh[i*WIDTH +: WIDTH])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            op_cnt    <= '0;
        end else begin
            if (acc)          s1_valid <= 1'b1;
            else if (s2_free) s1_valid <= 1'b0;
            if (ld2)            out_valid <= 1'b1;
            else if (out_ready) out_valid <= 1'b0;
            if (acc && op_cnt != {CNT_W{1'b1}})
                op_cnt <= op_cnt + 1'b1;
        end
    end
endmodule

// File: doc/masked_andxor_pipe.md
Name: masked_andxor_pipe

Overview:
- Parametrised, pipelined masked gadget computing q = (a & b) ^ c on NS-share Boolean-masked WIDTH-bit operands, using domain-oriented cross terms refreshed with fresh randomness.
- Generalises the fixed 3-share, 1-bit component functions to arbitrary share count and width.
- Adds a mandatory glitch-isolating register stage, valid/ready flow control, randomness gating and an operation counter.
- Sits inside masked S-box datapaths between linear layers.

Parameters:
- NS, 3, number of shares (>=2); security order NS-1.
- WIDTH, 4, bits per share.
- RW, NS*(NS-1)/2*WIDTH, fresh randomness bits consumed per operation (derived, not overridable).
- CNT_W, 16, width of the operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and c shares are valid.
- in_ready  out  1  block can accept an operation this cycle.
- a_sh  in  NS*WIDTH  shares of a; share i at bits [i*WIDTH +: WIDTH].
- b_sh  in  NS*WIDTH  shares of b, same packing.
- c_sh  in  NS*WIDTH  shares of c, same packing.
- rnd  in  RW  fresh randomness; pair (i<j) uses slice k = pair index in lexicographic order, bits [k*WIDTH +: WIDTH].
- rnd_valid  in  1  rnd holds unused fresh bits.
- out_valid  out  1  q_sh valid.
- out_ready  in  1  consumer accepts q_sh.
- q_sh  out  NS*WIDTH  shares of q.
- op_cnt  out  CNT_W  number of accepted operations.

Behaviour:
- Accept condition: acc = in_valid & rnd_valid & in_ready. Neither operand nor randomness is consumed unless acc is high.
- in_ready = !s1_valid | s2_free, where s2_free = !out_valid | out_ready.
- Stage 1 (registered on acc), for each share pair, bitwise:
  - Inner term t[i][i] = a_i & b_i ^ c_i.
  - Cross term t[i][j] (i != j) = a_i & b_j ^ r_{min(i,j),max(i,j)}.
  - All NS*NS terms are stored in dedicated flops.
  - No XOR of two different cross terms may precede this register; this is the glitch barrier, and synthesis keep attributes are required on the term registers.
- Stage 2 (output register, loaded when s1_valid & s2_free): q_i = XOR over j of t[i][j].
- Latency: 2 cycles from acc to out_valid with no backpressure; throughput 1 op/cycle.
- Backpressure:
  - While out_valid & !out_ready, q_sh and out_valid hold.
  - Stage 1 holds if it is also full, and in_ready drops.
  - No operation is dropped or duplicated.
- If in_valid=1 and rnd_valid=0: no accept, and in_ready is unaffected. The upstream source must hold its inputs; stage 1 does not load.
- Correctness: XOR of the q shares equals (XOR a_i) & (XOR b_i) ^ (XOR c_i) for every rnd value.
- op_cnt increments on each acc and saturates at all-ones (no wrap).
- Reset: asynchronous, applies mid-operation. Effects:
  - out_valid=0, s1_valid=0.
  - q_sh=0 and all term registers=0 (no residual share data).
  - op_cnt=0.
  - in_ready reads 1 combinationally during and after reset.
- Simultaneous events: in the same cycle, stage 2 drains to the consumer, stage 1 moves to stage 2 and a new op is accepted into stage 1.
- q_sh never changes while out_valid=1 and out_ready=0.

Test Plan:
- Reset defaults: NS=3, WIDTH=4, assert rst -> out_valid=0, q_sh=0, op_cnt=0, in_ready=1.
- Single op: a=0xA, b=0x6, c=0x1, random sharing and rnd, out_ready=1 -> out_valid high exactly 2 cycles after acc; unmasked q=0x3; op_cnt=1.
- Streaming: 64 back-to-back random ops with out_ready=1 -> one result per cycle, in order, all correct against the reference model; op_cnt=64.
- Backpressure: out_ready=0 for 5 cycles during a stream:
  - q_sh stable throughout;
  - in_ready falls after stage 1 fills;
  - on release, the sequence continues with no loss or duplication.
- Randomness starvation: in_valid=1, rnd_valid=0 for 3 cycles, then 1 -> no accept during starvation; single accept afterwards; op_cnt increments once.
- Reset mid-pipeline plus saturation:
  - rst asserted with both stages full -> outputs cleared immediately; the first post-reset op produces a correct result.
  - Separately, CNT_W=4 with 20 ops -> op_cnt=0xF.
